// File: rtl/decoder_pkg.sv
// Shared definitions for the 2-to-4 decoder: counter width default and select index type.
package decoder_pkg;

    localparam int CNT_W_DEF = 8;

    typedef logic [1:0] sel_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts edges with inc high, sticks at all-ones, clears on sync reset.
module sat_counter
    import decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Hold at all-ones rather than wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/decoder.sv
// 2-to-4 one-hot decoder with enable, a registered copy of the decode and per-output hit counters.
module decoder
    import decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             a,
    input  logic             b,
    input  logic             en,
    output logic             d0,
    output logic             d1,
    output logic             d2,
    output logic             d3,
    input  logic             clk,
    input  logic             rst,
    output logic [3:0]       dq,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    sel_t       sel;
    logic [3:0] dec;
    logic [3:0] dq_q;
    logic [3:0] dq_d;

    assign sel = {a, b};

    // A shift (not a case with a default) lets an X/Z select or enable propagate as X.
    always_comb begin
        dec = en ? (4'b0001 << sel) : 4'b0000;
    end

    assign d0 = dec[0];
    assign d1 = dec[1];
    assign d2 = dec[2];
    assign d3 = dec[3];

    assign dq_d = dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            dq_q <= 4'b0000;
        end else begin
            dq_q <= dq_d;
        end
    end

    assign dq = dq_q;

    sat_counter #(.CNT_W(CNT_W)) u_cnt0 (.clk(clk), .rst(rst), .inc(dec[0]), .cnt(cnt0));
    sat_counter #(.CNT_W(CNT_W)) u_cnt1 (.clk(clk), .rst(rst), .inc(dec[1]), .cnt(cnt1));
    sat_counter #(.CNT_W(CNT_W)) u_cnt2 (.clk(clk), .rst(rst), .inc(dec[2]), .cnt(cnt2));
    sat_counter #(.CNT_W(CNT_W)) u_cnt3 (.clk(clk), .rst(rst), .inc(dec[3]), .cnt(cnt3));

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed literal cases plus randomized run against a behavioural model.
module tb_decoder;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic en = 1'b0;
    logic rst = 1'b1;

    logic       d0, d1, d2, d3;
    logic [3:0] dq;
    logic [7:0] c0, c1, c2, c3;

    logic       s_d0, s_d1, s_d2, s_d3;
    logic [3:0] s_dq;
    logic [1:0] s0, s1, s2, s3;

    int checks = 0;
    int errors = 0;

    decoder u_dut (
        .a(a), .b(b), .en(en), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .clk(clk), .rst(rst), .dq(dq),
        .cnt0(c0), .cnt1(c1), .cnt2(c2), .cnt3(c3)
    );

    decoder #(.CNT_W(2)) u_sat (
        .a(a), .b(b), .en(en), .d0(s_d0), .d1(s_d1), .d2(s_d2), .d3(s_d3),
        .clk(clk), .rst(rst), .dq(s_dq),
        .cnt0(s0), .cnt1(s1), .cnt2(s2), .cnt3(s3)
    );

    initial forever #5 clk = clk_run ? ~clk : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one hit per edge on the selected output, clamped at 2^W-1.
    int  m_cnt8 [4];
    int  m_cnt2 [4];
    int  m_dq;
    bit  m_valid = 1'b0;

    always @(posedge clk) begin
        int idx;
        idx = a * 2 + b;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt8[i] <= 0;
                m_cnt2[i] <= 0;
            end
            m_dq    <= 0;
            m_valid <= 1'b1;
        end else if (en) begin
            m_dq <= 1 << idx;
            m_cnt8[idx] <= (m_cnt8[idx] < 255) ? m_cnt8[idx] + 1 : 255;
            m_cnt2[idx] <= (m_cnt2[idx] < 3) ? m_cnt2[idx] + 1 : 3;
        end else begin
            m_dq <= 0;
        end
    end

    // Compare process: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        int exp_d;
        exp_d = en ? (1 << (a * 2 + b)) : 0;
        chk("d_comb", {28'd0, d3, d2, d1, d0}, exp_d);
        chk("d_comb_w2", {28'd0, s_d3, s_d2, s_d1, s_d0}, exp_d);
        chk("d_onehot_or_zero", {31'd0, $onehot0({d3, d2, d1, d0})}, 32'd1);
        if (m_valid) begin
            chk("dq", {28'd0, dq}, m_dq);
            chk("dq_w2", {28'd0, s_dq}, m_dq);
            chk("cnt0", {24'd0, c0}, m_cnt8[0]);
            chk("cnt1", {24'd0, c1}, m_cnt8[1]);
            chk("cnt2", {24'd0, c2}, m_cnt8[2]);
            chk("cnt3", {24'd0, c3}, m_cnt8[3]);
            chk("cnt0_w2", {30'd0, s0}, m_cnt2[0]);
            chk("cnt1_w2", {30'd0, s1}, m_cnt2[1]);
            chk("cnt2_w2", {30'd0, s2}, m_cnt2[2]);
            chk("cnt3_w2", {30'd0, s3}, m_cnt2[3]);
        end
    end

    task automatic drive(input logic r, input logic e, input logic aa, input logic bb);
        rst = r;
        en  = e;
        a   = aa;
        b   = bb;
    endtask

    task automatic edge_then(input logic r, input logic e, input logic aa, input logic bb);
        @(posedge clk);
        #1;
        drive(r, e, aa, bb);
    endtask

    initial begin
        logic [3:0] exp4;
        // Combinational decode with the clock stopped.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, i[1], i[0]);
            #10;
            exp4 = 4'b0001 << i;
            chk("comb_en1", {28'd0, d3, d2, d1, d0}, {28'd0, exp4});
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, i[1], i[0]);
            #10;
            chk("comb_en0", {28'd0, d3, d2, d1, d0}, 32'd0);
        end

        // Reset for one edge, then select 10 for three edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        clk_run = 1'b1;
        edge_then(1'b0, 1'b1, 1'b1, 1'b0);
        chk("reset_dq", {28'd0, dq}, 32'd0);
        chk("reset_cnt2", {24'd0, c2}, 32'd0);
        edge_then(1'b0, 1'b1, 1'b1, 1'b0);
        chk("dq_after_1", {28'd0, dq}, 32'h4);
        edge_then(1'b0, 1'b1, 1'b1, 1'b0);
        edge_then(1'b0, 1'b1, 1'b1, 1'b0);
        chk("dir_cnt2", {24'd0, c2}, 32'd3);
        chk("dir_cnt0", {24'd0, c0}, 32'd0);
        chk("dir_cnt1", {24'd0, c1}, 32'd0);
        chk("dir_cnt3", {24'd0, c3}, 32'd0);
        chk("dir_dq", {28'd0, dq}, 32'h4);

        // Saturation: select 11 for five edges, then two more.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        edge_then(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (5) edge_then(1'b0, 1'b1, 1'b1, 1'b1);
        chk("sat_cnt3_w2", {30'd0, s3}, 32'd3);
        chk("sat_cnt3_w8", {24'd0, c3}, 32'd5);
        repeat (2) edge_then(1'b0, 1'b1, 1'b1, 1'b1);
        chk("sat_hold_w2", {30'd0, s3}, 32'd3);

        // Reset wins over an active d1 on the same edge.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (2) edge_then(1'b0, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_cnt1", {24'd0, c1}, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("rst_d1_comb", {31'd0, d1}, 32'd1);
        edge_then(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_cnt1", {24'd0, c1}, 32'd0);
        chk("rst_dq", {28'd0, dq}, 32'd0);
        chk("rst_d1_still", {31'd0, d1}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        edge_then(1'b0, 1'b1, 1'b0, 1'b1);
        chk("resume_cnt1", {24'd0, c1}, 32'd1);

        // Randomized run with occasional resets.
        for (int n = 0; n < 200; n++) begin
            edge_then(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom), 1'($urandom));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
